// File: rtl/bsg_manycore_gs_pkg.sv
// Shared types for the gather/scatter sequencer: FSM state, command record, default widths.
package bsg_manycore_gs_pkg;

  // The command record is sized by these; the top refuses other widths at elaboration.
  localparam int gs_x_cord_width_gp = 4;
  localparam int gs_y_cord_width_gp = 4;
  localparam int gs_addr_width_gp   = 32;
  localparam int gs_els_gp          = 16;
  localparam int gs_count_width_gp  = $clog2(gs_els_gp + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} gs_state_e;

  typedef enum logic {GS_GATHER = 1'b0, GS_SCATTER = 1'b1} gs_mode_e;

  typedef struct packed {
    gs_mode_e                      mode;
    logic [gs_x_cord_width_gp-1:0] x;
    logic [gs_y_cord_width_gp-1:0] y;
    logic [gs_addr_width_gp-1:0]   base;
    logic [gs_addr_width_gp-1:0]   stride;
    logic [gs_count_width_gp-1:0]  count;
  } gs_cmd_s;

endpackage

// File: rtl/bsg_manycore_gs_addr_gen.sv
// Element index and remote address generator: base plus a running stride accumulator,
// so no multiplier is needed; the sum wraps modulo 2^addr_width_p.
module bsg_manycore_gs_addr_gen #(
  parameter int addr_width_p = 32,
  parameter int idx_width_p  = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic [addr_width_p-1:0] base_i,
  input  logic [addr_width_p-1:0] stride_i,
  output logic [addr_width_p-1:0] addr_o,
  output logic [idx_width_p-1:0]  idx_o
);

  logic [addr_width_p-1:0] off_r;
  logic [idx_width_p-1:0]  idx_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      off_r <= '0;
      idx_r <= '0;
    end else if (load_i) begin
      off_r <= '0;
      idx_r <= '0;
    end else if (step_i) begin
      off_r <= off_r + stride_i;
      idx_r <= idx_r + 1'b1;
    end
  end

  assign addr_o = base_i + off_r;
  assign idx_o  = idx_r;

endmodule

// File: rtl/bsg_manycore_gs_sequencer.sv
// Gather/scatter sequencer: one command -> a strided burst of remote loads or stores via the endpoint.
// Optional watchdog under `BSG_MANYCORE_GS_TIMEOUT_EN (err_o tied low without it).
module bsg_manycore_gs_sequencer
  import bsg_manycore_gs_pkg::*;
#(
  parameter int x_cord_width_p    = gs_x_cord_width_gp,
  parameter int y_cord_width_p    = gs_y_cord_width_gp,
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = gs_addr_width_gp,
  parameter int load_id_width_p   = 11,
  parameter int els_p             = gs_els_gp,
  parameter int max_out_credits_p = 200,
  parameter int timeout_p         = 4096,
  localparam int cnt_w  = $clog2(els_p + 1),
  localparam int idx_w  = $clog2(els_p),
  localparam int cred_w = $clog2(max_out_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       cmd_v_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_scatter_i,
  input  logic [x_cord_width_p-1:0]  cmd_x_i,
  input  logic [y_cord_width_p-1:0]  cmd_y_i,
  input  logic [addr_width_p-1:0]    cmd_base_i,
  input  logic [addr_width_p-1:0]    cmd_stride_i,
  input  logic [cnt_w-1:0]           cmd_count_i,
  output logic                       out_v_o,
  input  logic                       out_ready_i,
  output logic                       out_we_o,
  output logic [x_cord_width_p-1:0]  out_x_o,
  output logic [y_cord_width_p-1:0]  out_y_o,
  output logic [addr_width_p-1:0]    out_addr_o,
  output logic [data_width_p-1:0]    out_data_o,
  output logic [load_id_width_p-1:0] out_load_id_o,
  input  logic [cred_w-1:0]          out_credits_i,
  input  logic                       returned_v_i,
  input  logic [data_width_p-1:0]    returned_data_i,
  input  logic [load_id_width_p-1:0] returned_load_id_i,
  output logic                       returned_yumi_o,
  input  logic                       host_v_i,
  input  logic                       host_we_i,
  input  logic [idx_w-1:0]           host_addr_i,
  input  logic [data_width_p-1:0]    host_data_i,
  output logic [data_width_p-1:0]    host_data_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  if (x_cord_width_p != gs_x_cord_width_gp || y_cord_width_p != gs_y_cord_width_gp ||
      addr_width_p != gs_addr_width_gp || els_p != gs_els_gp ||
      load_id_width_p < idx_w || timeout_p < 1) begin : g_bad_cfg
    $error("bsg_manycore_gs_sequencer: parameters do not match the gs_cmd_s layout");
  end

  gs_state_e               state_r;
  gs_cmd_s                 cmd_n, cmd_r;
  logic [cnt_w-1:0]        idx, ret_cnt_r;
  logic [addr_width_p-1:0] addr;
  logic [data_width_p-1:0] buf_r [els_p];
  logic fire, last_fire, gather_act, ret_take, ret_in_range, drain_done, wd_hit;

  always_comb begin
    cmd_n        = '0;
    cmd_n.mode   = cmd_scatter_i ? GS_SCATTER : GS_GATHER;
    cmd_n.x      = cmd_x_i;
    cmd_n.y      = cmd_y_i;
    cmd_n.base   = cmd_base_i;
    cmd_n.stride = cmd_stride_i;
    cmd_n.count  = cmd_count_i;
  end

  bsg_manycore_gs_addr_gen #(
    .addr_width_p (addr_width_p),
    .idx_width_p  (cnt_w)
  ) addr_gen (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (cmd_v_i & cmd_ready_o),
    .step_i   (fire),
    .base_i   (cmd_r.base),
    .stride_i (cmd_r.stride),
    .addr_o   (addr),
    .idx_o    (idx)
  );

  assign out_v_o       = (state_r == ISSUE) & (idx < cmd_r.count) & (out_credits_i != '0);
  assign fire          = out_v_o & out_ready_i;
  assign last_fire     = fire & ((idx + 1'b1) == cmd_r.count);
  assign out_we_o      = (cmd_r.mode == GS_SCATTER);
  assign out_x_o       = cmd_r.x;
  assign out_y_o       = cmd_r.y;
  assign out_addr_o    = addr;
  assign out_data_o    = buf_r[idx[idx_w-1:0]];
  assign out_load_id_o = load_id_width_p'(idx[idx_w-1:0]);

  // Returns are always consumed; only those belonging to an active gather touch the buffer.
  assign returned_yumi_o = returned_v_i;
  assign gather_act      = ((state_r == ISSUE) || (state_r == DRAIN)) && (cmd_r.mode == GS_GATHER);
  assign ret_take        = returned_v_i & gather_act;
  assign ret_in_range    = (returned_load_id_i >> idx_w) == '0;

  assign drain_done = (cmd_r.mode == GS_GATHER) ? (ret_cnt_r == cmd_r.count)
                                                : (out_credits_i == cred_w'(max_out_credits_p));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      cmd_r       <= '0;
      ret_cnt_r   <= '0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= (state_r == DONE);
      if (ret_take) ret_cnt_r <= ret_cnt_r + 1'b1;
      unique case (state_r)
        IDLE: if (cmd_v_i) begin
          cmd_r       <= cmd_n;
          ret_cnt_r   <= '0;
          cmd_ready_o <= 1'b0;
          busy_o      <= 1'b1;
          state_r     <= (cmd_n.count == '0) ? DONE : ISSUE;
        end
        ISSUE: if (last_fire) state_r <= DRAIN;
        DRAIN: if (drain_done) state_r <= DONE;
        DONE: begin
          state_r     <= IDLE;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: state_r <= IDLE;
      endcase
      if (wd_hit) state_r <= DONE;
    end
  end

  // Host and return writes never collide: host access requires IDLE, returns require ISSUE/DRAIN.
  always_ff @(posedge clk_i) begin
    if (!busy_o && host_v_i) begin
      if (host_we_i) buf_r[host_addr_i] <= host_data_i;
      else           host_data_o        <= buf_r[host_addr_i];
    end
    if (ret_take && ret_in_range) buf_r[returned_load_id_i[idx_w-1:0]] <= returned_data_i;
  end

`ifdef BSG_MANYCORE_GS_TIMEOUT_EN
  localparam int wd_w = $clog2(timeout_p + 1);
  logic [wd_w-1:0] wd_r;
  logic            err_r, stalled;

  assign stalled = ((state_r == ISSUE) || (state_r == DRAIN)) & ~fire & ~ret_take;
  assign wd_hit  = stalled & (wd_r == wd_w'(timeout_p - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wd_r  <= '0;
      err_r <= 1'b0;
    end else begin
      wd_r <= (stalled & ~wd_hit) ? wd_r + 1'b1 : '0;
      if (wd_hit) err_r <= 1'b1;
    end
  end

  assign err_o = err_r;
`else
  assign wd_hit = 1'b0;
  assign err_o  = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i && returned_v_i && !gather_act)
      $error("bsg_manycore_gs_sequencer: load return dropped outside an active gather");
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_gs_sequencer.sv
// Randomized bench: an endpoint model (credits, remote memory, delayed returns/acks) and a
// reference buffer; every request is checked against base + k*stride computed directly.
module tb_bsg_manycore_gs_sequencer;

  localparam int ELS  = 16;
  localparam int MAXC = 200;
  localparam int TMO  = 200;

  logic        clk, reset_i;
  logic        cmd_v_i, cmd_ready_o, cmd_scatter_i;
  logic [3:0]  cmd_x_i, cmd_y_i;
  logic [31:0] cmd_base_i, cmd_stride_i;
  logic [4:0]  cmd_count_i;
  logic        out_v_o, out_ready_i, out_we_o;
  logic [3:0]  out_x_o, out_y_o;
  logic [31:0] out_addr_o, out_data_o;
  logic [10:0] out_load_id_o;
  logic [7:0]  out_credits_i;
  logic        returned_v_i, returned_yumi_o;
  logic [31:0] returned_data_i;
  logic [10:0] returned_load_id_i;
  logic        host_v_i, host_we_i;
  logic [3:0]  host_addr_i;
  logic [31:0] host_data_i, host_data_o;
  logic        busy_o, done_o, err_o;

  bsg_manycore_gs_sequencer #(
    .x_cord_width_p(4), .y_cord_width_p(4), .data_width_p(32), .addr_width_p(32),
    .load_id_width_p(11), .els_p(ELS), .max_out_credits_p(MAXC), .timeout_p(TMO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_scatter_i(cmd_scatter_i),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .cmd_base_i(cmd_base_i),
    .cmd_stride_i(cmd_stride_i), .cmd_count_i(cmd_count_i),
    .out_v_o(out_v_o), .out_ready_i(out_ready_i), .out_we_o(out_we_o),
    .out_x_o(out_x_o), .out_y_o(out_y_o), .out_addr_o(out_addr_o),
    .out_data_o(out_data_o), .out_load_id_o(out_load_id_o), .out_credits_i(out_credits_i),
    .returned_v_i(returned_v_i), .returned_data_i(returned_data_i),
    .returned_load_id_i(returned_load_id_i), .returned_yumi_o(returned_yumi_o),
    .host_v_i(host_v_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_data_i(host_data_i), .host_data_o(host_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; int lid; } ret_t;

  int          n_chk, n_fail;
  int          cyc, last_samp, done_cyc, ndone, nret, k, credits, done_cred;
  int          cz_at, cz_left;
  bit          cred_zero, hold_ret, last_rdy;
  bit          exp_sc;
  logic [3:0]  exp_x, exp_y;
  logic [31:0] exp_base, exp_stride;
  int          exp_cnt;
  logic [31:0] mbuf [ELS];
  logic [31:0] rmem [logic [31:0]];
  ret_t        ldq [$];
  int          stq [$];
  logic [31:0] addr_q [$];
  logic [31:0] data_q [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_remote(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  // Endpoint side, driven just after each rising edge.
  task automatic drive_ep();
    cyc++;
    returned_v_i       = 1'b0;
    returned_data_i    = '0;
    returned_load_id_i = '0;
    if (!hold_ret && ldq.size() != 0 && ldq[0].due <= cyc) begin
      ret_t r;
      r = ldq.pop_front();
      returned_v_i       = 1'b1;
      returned_data_i    = r.data;
      returned_load_id_i = 11'(r.lid);
      mbuf[r.lid]        = r.data;
      credits++;
      nret++;
    end
    while (stq.size() != 0 && stq[0] <= cyc) begin
      void'(stq.pop_front());
      credits++;
    end
    cred_zero = (cz_left > 0) && (k >= cz_at);
    if (cred_zero) cz_left--;
    out_credits_i = cred_zero ? 8'd0 : 8'(credits);
    out_ready_i   = ($urandom_range(0, 3) != 0);
  endtask

  task automatic fire_model();
    logic [31:0] ea;
    ea = exp_base + exp_stride * 32'(k);
    chk("req_extra", 64'(k < exp_cnt), 64'd1);
    chk("req_addr", out_addr_o, ea);
    chk("req_lid", out_load_id_o, 64'(k));
    chk("req_we", out_we_o, exp_sc);
    chk("req_xy", {out_x_o, out_y_o}, {exp_x, exp_y});
    if (exp_sc) chk("req_data", out_data_o, mbuf[k % ELS]);
    addr_q.push_back(out_addr_o);
    credits--;
    if (exp_sc) begin
      data_q.push_back(out_data_o);
      rmem[ea] = out_data_o;
      stq.push_back(cyc + int'($urandom_range(3, 12)));
    end else begin
      ldq.push_back('{cyc + int'($urandom_range(1, 6)), rd_remote(ea), k});
    end
    k++;
  endtask

  // One clock: sample at the falling edge, then drive the next cycle's endpoint inputs.
  task automatic cycle();
    @(negedge clk);
    last_rdy  = cmd_ready_o;
    last_samp = cyc;
    if (cred_zero) chk("nocred_v", out_v_o, 0);
    if (out_v_o && out_ready_i) fire_model();
    if (done_o) begin
      ndone++;
      done_cyc  = cyc;
      done_cred = credits;
    end
    @(posedge clk);
    #1;
    drive_ep();
  endtask

  task automatic host_wr(input int a, input logic [31:0] d);
    host_v_i = 1'b1; host_we_i = 1'b1; host_addr_i = 4'(a); host_data_i = d;
    cycle();
    host_v_i = 1'b0; host_we_i = 1'b0;
    mbuf[a] = d;
  endtask

  task automatic host_rd(input int a, output logic [31:0] d);
    host_v_i = 1'b1; host_we_i = 1'b0; host_addr_i = 4'(a);
    cycle();
    host_v_i = 1'b0;
    d = host_data_o;
  endtask

  task automatic start_cmd(input bit sc, input logic [3:0] x, input logic [3:0] y,
                           input logic [31:0] base, input logic [31:0] stride, input int cnt,
                           output int acc);
    exp_sc = sc; exp_x = x; exp_y = y; exp_base = base; exp_stride = stride; exp_cnt = cnt;
    k = 0; nret = 0; ndone = 0;
    addr_q.delete(); data_q.delete();
    cmd_v_i = 1'b1; cmd_scatter_i = sc; cmd_x_i = x; cmd_y_i = y;
    cmd_base_i = base; cmd_stride_i = stride; cmd_count_i = 5'(cnt);
    cycle();
    chk("cmd_ready", last_rdy, 1);
    acc = last_samp;
    cmd_v_i = 1'b0;
  endtask

  task automatic run_cmd(input bit sc, input logic [3:0] x, input logic [3:0] y,
                         input logic [31:0] base, input logic [31:0] stride, input int cnt);
    int acc;
    logic [31:0] d;
    start_cmd(sc, x, y, base, stride, cnt, acc);
    for (int t = 0; t < 2000 && ndone == 0; t++) cycle();
    if (ndone == 0) chk("done_wait", 0, 1);
    if (cnt == 0) chk("zero_done_lat", 64'(done_cyc - acc), 64'd2);
    if (sc) begin
      chk("scat_cred_at_done", 64'(done_cred), 64'(MAXC));
      chk("scat_acks_left", 64'(stq.size()), 0);
    end else begin
      chk("gath_returns", 64'(nret), 64'(cnt));
    end
    cycle();
    cycle();
    chk("fires", 64'(k), 64'(cnt));
    chk("done_pulses", 64'(ndone), 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_ready", cmd_ready_o, 1);
    if (!sc && cnt != 0) begin
      for (int i = 0; i < ELS; i++) begin
        host_rd(i, d);
        chk("gath_buf", d, mbuf[i]);
      end
    end
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, s;
    int acc;
    n_chk = 0; n_fail = 0; cyc = 0; k = 0; ndone = 0; nret = 0;
    credits = MAXC; cz_at = 0; cz_left = 0; cred_zero = 0; hold_ret = 0;
    exp_sc = 0; exp_cnt = 0; exp_x = '0; exp_y = '0; exp_base = '0; exp_stride = '0;
    reset_i = 1'b1; cmd_v_i = 0; cmd_scatter_i = 0; cmd_x_i = '0; cmd_y_i = '0;
    cmd_base_i = '0; cmd_stride_i = '0; cmd_count_i = '0;
    out_ready_i = 0; out_credits_i = 8'(MAXC); returned_v_i = 0;
    returned_data_i = '0; returned_load_id_i = '0;
    host_v_i = 0; host_we_i = 0; host_addr_i = '0; host_data_i = '0;
    #1;
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_out_v", out_v_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    drive_ep();

    for (int i = 0; i < ELS; i++) host_wr(i, $urandom);
    host_wr(5, 32'h1234_5678);
    host_rd(5, d);
    chk("host_wr_rd", d, 32'h1234_5678);

    // Gather of four known remote words
    for (int i = 0; i < 4; i++) rmem[32'h100 + 32'(i)] = 32'hA0 + 32'(i);
    run_cmd(0, 4'h2, 4'h3, 32'h100, 32'd1, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", addr_q[i], 32'h100 + 32'(i));
      host_rd(i, d);
      chk("t1_buf", d, 32'hA0 + 32'(i));
    end

    // Scatter 0x11,0x22,0x33 at stride 4
    host_wr(0, 32'h11); host_wr(1, 32'h22); host_wr(2, 32'h33);
    run_cmd(1, 4'h7, 4'h1, 32'h4000, 32'd4, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_addr", addr_q[i], 32'h4000 + 32'(4 * i));
      chk("t2_data", data_q[i], 32'h11 * 32'(i + 1));
    end

    // Credit starvation for 10 cycles after the second request
    cz_at = 2; cz_left = 10;
    run_cmd(0, 4'h1, 4'h1, 32'h800, 32'd3, 8);
    chk("t3_cz_used", 64'(cz_left), 0);

    // Empty command
    run_cmd(0, 4'h0, 4'h0, 32'h0, 32'd1, 0);

    // Address wrap
    run_cmd(0, 4'h5, 4'h6, 32'hFFFF_FFFE, 32'd1, 3);
    chk("t5_a0", addr_q[0], 32'hFFFF_FFFE);
    chk("t5_a1", addr_q[1], 32'hFFFF_FFFF);
    chk("t5_a2", addr_q[2], 32'h0000_0000);

    // Randomized commands
    for (int n = 0; n < 10; n++) begin
      for (int j = 0; j < 3; j++) host_wr(int'($urandom_range(0, ELS - 1)), $urandom);
      case ($urandom_range(0, 3))
        0: s = 32'd1;
        1: s = 32'd4;
        2: s = 32'hFFFF_FFFF;
        default: s = $urandom;
      endcase
      run_cmd(bit'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), $urandom, s,
              int'($urandom_range(0, ELS)));
    end

    // Reset while draining a gather whose returns are withheld
    hold_ret = 1;
    start_cmd(0, 4'h3, 4'h4, 32'h200, 32'd2, 4, acc);
    for (int t = 0; t < 200 && k < 4; t++) cycle();
    chk("t6_issued", 64'(k), 4);
    repeat (5) cycle();
    chk("t6_drain_busy", busy_o, 1);
    chk("t6_no_done", 64'(ndone), 0);
`ifndef BSG_MANYCORE_GS_TIMEOUT_EN
    repeat (50) cycle();
    chk("t6_err_off", err_o, 0);
`endif
    reset_i = 1'b1;
    #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_ready", cmd_ready_o, 1);
    chk("t6_rst_out_v", out_v_o, 0);
    ldq.delete();
    credits = MAXC;
    cycle();
    reset_i = 1'b0;
    cycle();

`ifdef BSG_MANYCORE_GS_TIMEOUT_EN
    start_cmd(0, 4'h1, 4'h2, 32'h300, 32'd1, 2, acc);
    for (int t = 0; t < TMO + 100 && ndone == 0; t++) cycle();
    chk("wd_done", 64'(ndone), 1);
    chk("wd_err", err_o, 1);
    repeat (3) cycle();
    chk("wd_err_sticky", err_o, 1);
    chk("wd_idle", busy_o, 0);
    reset_i = 1'b1;
    #1;
    chk("wd_err_clr", err_o, 0);
    ldq.delete();
    credits = MAXC;
    cycle();
    reset_i = 1'b0;
    cycle();
`endif
    hold_ret = 0;

    // Normal traffic still works after the reset
    run_cmd(0, 4'h9, 4'hA, 32'h5000, 32'd8, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
